wl_mag_sqrt: RTL and testbench

//  Gradient-magnitude stage of the canny pipeline: consumes two unsigned squared

---
 rtl/wl_mag_sqrt_pkg.sv | 14 +
 rtl/wl_sqrt_stage.sv | 68 ++++++
 rtl/wl_mag_sqrt.sv | 120 ++++++++++++
 tb/tb_wl_mag_sqrt.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/wl_mag_sqrt_pkg.sv
// Shared parameters and width helpers for the gradient-magnitude square-root pipeline.
package wl_mag_sqrt_pkg;

  localparam int SW_DEFAULT   = 16;
  localparam int OW_DEFAULT   = 8;
  localparam int TW_DEFAULT   = 2;
  localparam int OREG_DEFAULT = 1;

  // One root bit comes out per pair of radicand bits; the sum is SW+1 bits wide.
  function automatic int root_width(input int sw);
    return (sw + 2) / 2;
  endfunction

endpackage

// File: rtl/wl_sqrt_stage.sv
// One digit-by-digit square-root iteration with its valid/tag pipeline register.
module wl_sqrt_stage
  import wl_mag_sqrt_pkg::*;
#(
  parameter int RW    = 9,
  parameter int TW    = 2,
  parameter int STAGE = 0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            i_vld,
  input  logic [2*RW-1:0] i_rad,
  input  logic [RW+1:0]   i_rem,
  input  logic [RW-1:0]   i_root,
  input  logic [TW-1:0]   i_tag,
  output logic            o_vld,
  output logic [2*RW-1:0] o_rad,
  output logic [RW+1:0]   o_rem,
  output logic [RW-1:0]   o_root,
  output logic [TW-1:0]   o_tag
);

  logic            r_vld;
  logic [2*RW-1:0] r_rad;
  logic [RW+1:0]   r_rem;
  logic [RW-1:0]   r_root;
  logic [TW-1:0]   r_tag;

  logic [1:0]      w_pair;
  logic [RW+3:0]   w_acc;
  logic [RW+3:0]   w_sub;
  logic [RW+1:0]   w_acc_lo;
  logic [RW+1:0]   w_sub_lo;
  logic            w_ge;

  // The incoming remainder is always below 2^RW, so the low RW+2 bits hold the trial exactly.
  assign w_pair   = i_rad[2*(RW-1-STAGE) +: 2];
  assign w_acc    = {i_rem, w_pair};
  assign w_sub    = {2'b00, i_root, 2'b01};
  assign w_ge     = (w_acc >= w_sub);
  assign w_acc_lo = {i_rem[RW-1:0], w_pair};
  assign w_sub_lo = {i_root, 2'b01};

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_vld  <= 1'b0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_tag  <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_rad  <= i_rad;
        r_rem  <= w_ge ? (w_acc_lo - w_sub_lo) : w_acc_lo;
        r_root <= {i_root[RW-2:0], w_ge};
        r_tag  <= i_tag;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_rad  = r_rad;
  assign o_rem  = r_rem;
  assign o_root = r_root;
  assign o_tag  = r_tag;

endmodule

// File: rtl/wl_mag_sqrt.sv
// Gradient magnitude: floor(sqrt(gx^2 + gy^2)) with saturation, fully pipelined, tag aligned.
module wl_mag_sqrt
  import wl_mag_sqrt_pkg::*;
#(
  parameter int SW   = SW_DEFAULT,
  parameter int OW   = OW_DEFAULT,
  parameter int TW   = TW_DEFAULT,
  parameter int OREG = OREG_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            din_vld,
  input  logic [2*SW-1:0] din,
  input  logic [TW-1:0]   tag_in,
  output logic            dout_vld,
  output logic [OW-1:0]   dout,
  output logic            dsat,
  output logic [TW-1:0]   tag_out
);

  localparam int RW = root_width(SW);

  logic            r_vld0;
  logic [SW:0]     r_sum;
  logic [TW-1:0]   r_tag0;

  logic            w_vld  [RW+1];
  logic [2*RW-1:0] w_rad  [RW+1];
  logic [RW+1:0]   w_rem  [RW+1];
  logic [RW-1:0]   w_root [RW+1];
  logic [TW-1:0]   w_tag  [RW+1];

  logic [OW-1:0]   w_mag;
  logic            w_sat;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_vld0 <= 1'b0;
      r_sum  <= '0;
      r_tag0 <= '0;
    end else begin
      r_vld0 <= din_vld;
      if (din_vld) begin
        r_sum  <= {1'b0, din[SW-1:0]} + {1'b0, din[2*SW-1:SW]};
        r_tag0 <= tag_in;
      end
    end
  end

  assign w_vld[0]  = r_vld0;
  assign w_rad[0]  = (2*RW)'(r_sum);
  assign w_rem[0]  = '0;
  assign w_root[0] = '0;
  assign w_tag[0]  = r_tag0;

  for (genvar k = 0; k < RW; k++) begin : g_stage
    wl_sqrt_stage #(
      .RW   (RW),
      .TW   (TW),
      .STAGE(k)
    ) u_stage (
      .clk   (clk),
      .rst_b (rst_b),
      .i_vld (w_vld[k]),
      .i_rad (w_rad[k]),
      .i_rem (w_rem[k]),
      .i_root(w_root[k]),
      .i_tag (w_tag[k]),
      .o_vld (w_vld[k+1]),
      .o_rad (w_rad[k+1]),
      .o_rem (w_rem[k+1]),
      .o_root(w_root[k+1]),
      .o_tag (w_tag[k+1])
    );
  end

  // A root wider than the output can only overflow when OW < RW.
  if (OW < RW) begin : g_clamp
    assign w_sat = |w_root[RW][RW-1:OW];
    assign w_mag = w_sat ? {OW{1'b1}} : w_root[RW][OW-1:0];
  end else begin : g_noclamp
    assign w_sat = 1'b0;
    assign w_mag = OW'(w_root[RW]);
  end

  if (OREG != 0) begin : g_oreg
    logic            r_dout_vld;
    logic [OW-1:0]   r_dout;
    logic            r_dsat;
    logic [TW-1:0]   r_tag_out;

    always_ff @(posedge clk) begin
      if (!rst_b) begin
        r_dout_vld <= 1'b0;
        r_dout     <= '0;
        r_dsat     <= 1'b0;
        r_tag_out  <= '0;
      end else begin
        r_dout_vld <= w_vld[RW];
        if (w_vld[RW]) begin
          r_dout    <= w_mag;
          r_dsat    <= w_sat;
          r_tag_out <= w_tag[RW];
        end
      end
    end

    assign dout_vld = r_dout_vld;
    assign dout     = r_dout;
    assign dsat     = r_dsat;
    assign tag_out  = r_tag_out;
  end else begin : g_nooreg
    // Stage data only advances on valid, so the last stage already holds its value.
    assign dout_vld = w_vld[RW];
    assign dout     = w_mag;
    assign dsat     = w_sat;
    assign tag_out  = w_tag[RW];
  end

endmodule

// File: tb/tb_wl_mag_sqrt.sv
// Directed bench for wl_mag_sqrt at default parameters (latency 11).
module tb_wl_mag_sqrt;

  localparam int SW  = 16;
  localparam int OW  = 8;
  localparam int TW  = 2;
  localparam int LAT = 11;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            din_vld;
  logic [2*SW-1:0] din;
  logic [TW-1:0]   tag_in;
  logic            dout_vld;
  logic [OW-1:0]   dout;
  logic            dsat;
  logic [TW-1:0]   tag_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wl_mag_sqrt #(
    .SW  (SW),
    .OW  (OW),
    .TW  (TW),
    .OREG(1)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .din_vld (din_vld),
    .din     (din),
    .tag_in  (tag_in),
    .dout_vld(dout_vld),
    .dout    (dout),
    .dsat    (dsat),
    .tag_out (tag_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Present one sample for a single cycle, then scramble the idle inputs.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [1:0] tag);
    din     = {b, a};
    tag_in  = tag;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    din     = $urandom;
    tag_in  = 2'($urandom);
  endtask

  task automatic runVector(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] tag, input int expDout, input int expSat);
    int lat;
    lat = 1;
    applyStimulus(a, b, tag);
    while (dout_vld !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " latency"}, lat, LAT);
    checkOutput({name, " dout"}, dout, expDout);
    checkOutput({name, " dsat"}, dsat, expSat);
    checkOutput({name, " tag"}, tag_out, tag);
    @(posedge clk);
    #1;
    checkOutput({name, " pulse"}, dout_vld, 0);
    checkOutput({name, " hold"}, dout, expDout);
  endtask

  logic [15:0] sA   [8] = '{16'd100, 16'd7, 16'd1000, 16'd2, 16'd5, 16'd50000, 16'd63999, 16'd3};
  logic [15:0] sB   [8] = '{16'd21, 16'd7, 16'd24, 16'd0, 16'd5, 16'd50000, 16'd1, 16'd0};
  logic        sV   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0]  sT   [8] = '{2'd1, 2'd0, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd3};
  int          sOut [8] = '{11, 11, 32, 1, 1, 255, 252, 1};
  int          sSat [8] = '{0, 0, 0, 0, 0, 1, 0, 0};

  logic [15:0] rA [5] = '{16'd400, 16'd9, 16'd1, 16'd7, 16'd144};
  logic [15:0] rB [5] = '{16'd0, 16'd16, 16'd1, 16'd9, 16'd25};

  initial begin
    int lat;
    rst_b   = 1'b0;
    din_vld = 1'b0;
    din     = '0;
    tag_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset dout_vld", dout_vld, 0);
    checkOutput("reset dout", dout, 0);
    checkOutput("reset dsat", dsat, 0);
    checkOutput("reset tag_out", tag_out, 0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    runVector("sum25", 16'd9, 16'd16, 2'd2, 5, 0);
    runVector("sum24", 16'd24, 16'd0, 2'd1, 4, 0);
    runVector("sum0", 16'd0, 16'd0, 2'd3, 0, 0);
    runVector("sum130050", 16'd65025, 16'd65025, 2'd1, 255, 1);
    runVector("sum65025", 16'd65025, 16'd0, 2'd2, 255, 0);
    runVector("sum65535", 16'd65535, 16'd0, 2'd0, 255, 0);
    runVector("sum65536", 16'd65535, 16'd1, 2'd3, 255, 1);
    runVector("sum131070", 16'd65535, 16'd65535, 2'd2, 255, 1);

    // Gapped stream: valid pattern must reappear 11 cycles later, holding dout in the gaps.
    for (int i = 0; i < 8; i++) begin
      din     = {sB[i], sA[i]};
      din_vld = sV[i];
      tag_in  = sT[i];
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    repeat (LAT - 9) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream%0d vld", i), dout_vld, sV[i]);
      checkOutput($sformatf("stream%0d dout", i), dout, sOut[i]);
      checkOutput($sformatf("stream%0d dsat", i), dsat, sSat[i]);
      if (sV[i]) checkOutput($sformatf("stream%0d tag", i), tag_out, sT[i]);
    end
    @(posedge clk);
    #1;

    // Reset pulse in the middle of a back-to-back stream drops everything in flight.
    for (int i = 0; i < 5; i++) begin
      din     = {rB[i], rA[i]};
      din_vld = 1'b1;
      tag_in  = 2'd2;
      rst_b   = (i == 3) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    rst_b   = 1'b1;
    checkOutput("midreset dout cleared", dout, 0);
    lat = 1;
    while (dout_vld !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("midreset latency", lat, LAT);
    checkOutput("midreset dout", dout, 13);
    checkOutput("midreset dsat", dsat, 0);
    checkOutput("midreset tag", tag_out, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
